// File: rtl/up16_trace_buf.sv
// rtl/up16_trace_buf.sv - PC-triggered trace buffer for the up16 pipeline.
// Define UP16_TRACE_DEDUP_EN to drop repeated-PC (stall) samples during capture.
module up16_trace_buf #(
  parameter int ISIZE = 18,
  parameter int DSIZE = 16,
  parameter int DEPTH = 16
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [DSIZE-1:0]            currPC,
  input  logic [ISIZE-1:0]            inst,
  input  logic [3:0]                  ALUstatus,
  input  logic                        arm,
  input  logic [DSIZE-1:0]            trig_PC,
  input  logic                        stop,
  input  logic                        rd_req,
  output logic                        rd_valid,
  output logic [4+ISIZE+DSIZE-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic [1:0]                  state
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 4 + ISIZE + DSIZE;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ZERO = 0;
  localparam logic [AW:0]   CNT_LAST = DEPTH - 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic [W-1:0]  mem [DEPTH];

  logic          wr_en;
  logic          rd_en;
  logic          arm_ok;
  logic          dup_pc;
  logic [W-1:0]  wr_data;

`ifdef UP16_TRACE_DEDUP_EN
  logic [DSIZE-1:0] last_pc_q, last_pc_d;

  // Every session starts with a write in ARMED, so last_pc_q is always
  // meaningful once CAPTURE is reached.
  assign dup_pc = (currPC == last_pc_q);

  always_comb begin
    last_pc_d = last_pc_q;
    if (wr_en) last_pc_d = currPC;
  end

  always_ff @(posedge Clk) begin
    if (Rst) last_pc_q <= '0;
    else     last_pc_q <= last_pc_d;
  end
`else
  assign dup_pc = 1'b0;
`endif

  assign wr_data = {ALUstatus, inst, currPC};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wr_en      = 1'b0;
    rd_en      = rd_req && (count_q != CNT_ZERO);
    arm_ok     = arm && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (currPC == trig_PC) begin
          wr_en   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_d = DONE;
        end else if (!dup_pc) begin
          wr_en = 1'b1;
          // Leaving on the filling write guarantees no entry is overwritten.
          if (!rd_en && (count_q == CNT_LAST)) state_d = DONE;
        end
      end
      DONE: begin
        if (arm)                        state_d = ARMED;
        else if (count_q == CNT_ZERO)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
    end
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};

    // A new session discards whatever the previous one left behind.
    if (arm_ok) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = CNT_ZERO;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst && wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == CNT_ZERO);
  assign state    = state_q;

endmodule

// File: tb/tb_up16_trace_buf.sv
// tb/tb_up16_trace_buf.sv - scoreboard bench for up16_trace_buf.
module tb_up16_trace_buf;

  logic        Clk;
  logic        Rst;
  logic [15:0] currPC;
  logic [17:0] inst;
  logic [3:0]  ALUstatus;
  logic        arm;
  logic [15:0] trig_PC;
  logic        stop;
  logic        rd_req;
  logic        rd_valid;
  logic [37:0] rd_data;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int vld_seen = 0;
  int max_cnt;
  logic [37:0] exp_q[$];

  up16_trace_buf #(.ISIZE(18), .DSIZE(16), .DEPTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .currPC(currPC), .inst(inst), .ALUstatus(ALUstatus),
    .arm(arm), .trig_PC(trig_PC), .stop(stop), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .full(full),
    .empty(empty), .state(state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [37:0] entry(input logic [15:0] p);
    return {p[3:0] ^ 4'hC, 2'b01, p ^ 16'h5A00, p};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] p);
    currPC    = p;
    inst      = {2'b01, p ^ 16'h5A00};
    ALUstatus = p[3:0] ^ 4'hC;
  endtask

  always @(negedge Clk) begin
    if (rd_valid === 1'b1) begin
      vld_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got data %0h expected no read", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dd_seq [5];
    Rst = 1'b1; arm = 1'b0; stop = 1'b0; rd_req = 1'b0; trig_PC = 16'h0;
    set_pc(16'h0);
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);

    Rst = 1'b0; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("empty_read_valid", rd_valid, 0);
    chk("idle_state", state, 0);

    // Trigger at PC 4, fill to DEPTH; arm mid-capture must be ignored.
    arm = 1'b1; trig_PC = 16'h0004; set_pc(16'h0);
    step();
    arm = 1'b0;
    chk("armed_state", state, 1);
    for (int p = 1; p <= 19; p++) begin
      set_pc(16'(p));
      arm = (p == 10);
      step();
      if (p == 4) chk("capture_state", state, 2);
    end
    arm = 1'b0;
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_state", state, 3);

    set_pc(16'd20); stop = 1'b1;
    step();
    stop = 1'b0;
    chk("done_stop_count", count, 16);
    chk("done_stop_state", state, 3);

    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(entry(16'(4 + i)));
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      step();
    end
    chk("readout_empty", empty, 1);
    chk("readout_count", count, 0);
    chk("readout_state", state, 0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("read17_valid", rd_valid, 0);
    chk("read17_hold", rd_data, entry(16'd19));
    chk("readout_valids", vld_seen, 16);

    // Read held during capture: count never exceeds 1, all entries delivered.
    arm = 1'b1; trig_PC = 16'h0030; set_pc(16'h002E); rd_req = 1'b1;
    step();
    arm = 1'b0;
    max_cnt = 0;
    for (int p = 16'h2F; p <= 16'h37; p++) begin
      set_pc(16'(p));
      if (p >= 16'h30) exp_q.push_back(entry(16'(p)));
      step();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    set_pc(16'h0038); stop = 1'b1;
    step();
    stop = 1'b0;
    if (int'(count) > max_cnt) max_cnt = int'(count);
    chk("conc_stop_state", state, 3);
    step();
    rd_req = 1'b0;
    chk("conc_max_count", max_cnt, 1);
    chk("conc_count", count, 0);
    chk("conc_state", state, 0);
    chk("conc_valids", vld_seen, 24);

    // Stalled PC: 7, 8, 8, 8, 9 captured, then stop.
    dd_seq[0] = 16'd7; dd_seq[1] = 16'd8; dd_seq[2] = 16'd8;
    dd_seq[3] = 16'd8; dd_seq[4] = 16'd9;
    arm = 1'b1; trig_PC = 16'h0007; set_pc(16'd6);
    step();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_pc(dd_seq[i]);
`ifdef UP16_TRACE_DEDUP_EN
      if (i == 0 || i == 1 || i == 4) exp_q.push_back(entry(dd_seq[i]));
`else
      exp_q.push_back(entry(dd_seq[i]));
`endif
      step();
    end
    set_pc(16'd10); stop = 1'b1;
    step();
    stop = 1'b0;
`ifdef UP16_TRACE_DEDUP_EN
    chk("dedup_count", count, 3);
`else
    chk("dedup_count", count, 5);
`endif
    chk("dedup_state", state, 3);
    rd_req = 1'b1;
    repeat (5) step();
    rd_req = 1'b0;
    step();
    chk("dedup_empty", empty, 1);
    chk("dedup_idle", state, 0);

    // Reset asserted mid-capture with a read pending.
    arm = 1'b1; trig_PC = 16'h0040; set_pc(16'h003F);
    step();
    arm = 1'b0;
    for (int p = 16'h40; p <= 16'h42; p++) begin
      set_pc(16'(p));
      step();
    end
    chk("pre_rst_count", count, 3);
    chk("pre_rst_state", state, 2);
    Rst = 1'b1; rd_req = 1'b1; set_pc(16'h0043);
    step();
    chk("mid_rst_state", state, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    Rst = 1'b0; rd_req = 1'b0;
    step();
    chk("post_rst_valid", rd_valid, 0);
    chk("post_rst_state", state, 0);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
